servo_pwm_decoder: RTL and testbench

- Receive-side counterpart of the servo PWM generators: samples one servo PWM line and measures its high time and its rising-to-rising period in clk cycles.
- Converts the high time back to an integer angle (0..180) using the same mapping the generators use: pulse = PULSE_MIN + STEP*angle.
- Used in loopback self-test of the arm/spray servo outputs and as an on-board monitor; reports range, period and signal-loss faults.

---
 rtl/servo_pwm_decoder.sv | 231 +++++++++++++++++++++++
 tb/tb_servo_pwm_decoder.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_decoder.sv
// rtl/servo_pwm_decoder.sv - servo PWM receiver: measures high time and period, decodes angle
//
// Ports:
//   clk, rst_n     single clock domain, asynchronous active-low reset
//   pwm_in         asynchronous servo PWM line
//   angle          last decoded angle, 0..ANGLE_MAX
//   width          last accepted high time (cycles)
//   period         last measured rise-to-rise period (cycles)
//   angle_valid    1-cycle strobe, angle/width updated
//   period_valid   1-cycle strobe, period updated and in range
//   width_err      1-cycle strobe, high time out of range
//   period_err     1-cycle strobe, period out of range (period still latched)
//   signal_lost    level, no rising edge within TIMEOUT cycles
//   busy           level, angle conversion in progress

module servo_pwm_decoder #(
    parameter int PULSE_MIN  = 25000,
    parameter int STEP       = 555,
    parameter int ANGLE_MAX  = 180,
    parameter int WIDTH_MIN  = 20000,
    parameter int WIDTH_MAX  = 130000,
    parameter int PERIOD_MIN = 900000,
    parameter int PERIOD_MAX = 1100000,
    parameter int TIMEOUT    = 1500000,
    parameter int CW         = 21
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pwm_in,
    output logic [7:0]    angle,
    output logic [CW-1:0] width,
    output logic [CW-1:0] period,
    output logic          angle_valid,
    output logic          period_valid,
    output logic          width_err,
    output logic          period_err,
    output logic          signal_lost,
    output logic          busy
);

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] TO_LIM  = CW'(TIMEOUT - 1);
    localparam logic [CW:0]   PM_W    = (CW+1)'(PULSE_MIN);
    localparam logic [CW:0]   ST_W    = (CW+1)'(STEP);
    localparam logic [CW:0]   HALF_W  = (CW+1)'(STEP / 2);
    localparam logic [CW:0]   WMIN_W  = (CW+1)'(WIDTH_MIN);
    localparam logic [CW:0]   WMAX_W  = (CW+1)'(WIDTH_MAX);
    localparam logic [CW:0]   PMIN_W  = (CW+1)'(PERIOD_MIN);
    localparam logic [CW:0]   PMAX_W  = (CW+1)'(PERIOD_MAX);
    localparam logic [7:0]    A_MAX   = 8'(ANGLE_MAX);

    typedef enum logic [1:0] {
        ARM       = 2'd0,
        WAIT_RISE = 2'd1,
        HIGH      = 2'd2,
        LOW       = 2'd3
    } state_t;

    state_t state, state_n;

    // Synchronizer and edge-history flops reset to 1: the line is treated as
    // high until it is actually seen low, so ARM cannot leave on a stale 0 and
    // a pulse already in progress at reset release is never measured.
    logic sync1, sync2, sync_d;
    logic rise, fall;

    logic [CW-1:0] hi_cnt, per_cnt, to_cnt;
    logic [CW:0]   hi_len, per_len;
    logic [CW:0]   rem;
    logic [7:0]    q;

    logic timeout, cnt_clear, lost_set, lost_clr, fall_eval, rise_eval;
    logic width_ok, period_ok, conv_load;

    assign rise = sync2 & ~sync_d;
    assign fall = ~sync2 & sync_d;

    // Counters hold (length - 1) on the edge cycle, hence the +1.
    assign hi_len  = {1'b0, hi_cnt} + 1'b1;
    assign per_len = {1'b0, per_cnt} + 1'b1;

    assign width_ok  = (hi_len >= WMIN_W) && (hi_len <= WMAX_W);
    assign period_ok = (per_len >= PMIN_W) && (per_len <= PMAX_W);
    assign conv_load = fall_eval && width_ok;
    assign timeout   = (state != ARM) && (to_cnt >= TO_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARM;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_clear = 1'b0;
        lost_set  = 1'b0;
        lost_clr  = 1'b0;
        fall_eval = 1'b0;
        rise_eval = 1'b0;
        case (state)
            ARM: begin
                if (!sync2) begin
                    state_n = WAIT_RISE;
                end
            end
            WAIT_RISE: begin
                if (rise) begin
                    cnt_clear = 1'b1;
                    lost_clr  = 1'b1;
                    state_n   = HIGH;
                end else if (timeout) begin
                    lost_set = 1'b1;
                    state_n  = ARM;
                end
            end
            HIGH: begin
                if (fall) begin
                    fall_eval = 1'b1;
                    state_n   = LOW;
                end else if (timeout) begin
                    lost_set = 1'b1;
                    state_n  = ARM;
                end
            end
            LOW: begin
                if (rise) begin
                    rise_eval = 1'b1;
                    cnt_clear = 1'b1;
                    state_n   = HIGH;
                end else if (timeout) begin
                    lost_set = 1'b1;
                    state_n  = ARM;
                end
            end
            default: state_n = ARM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1        <= 1'b1;
            sync2        <= 1'b1;
            sync_d       <= 1'b1;
            hi_cnt       <= '0;
            per_cnt      <= '0;
            to_cnt       <= '0;
            rem          <= '0;
            q            <= '0;
            angle        <= '0;
            width        <= '0;
            period       <= '0;
            angle_valid  <= 1'b0;
            period_valid <= 1'b0;
            width_err    <= 1'b0;
            period_err   <= 1'b0;
            signal_lost  <= 1'b1;
            busy         <= 1'b0;
        end else begin
            sync1  <= pwm_in;
            sync2  <= sync1;
            sync_d <= sync2;

            angle_valid  <= 1'b0;
            period_valid <= 1'b0;
            width_err    <= 1'b0;
            period_err   <= 1'b0;

            // Cycles since the last accepted rise (or since leaving ARM).
            if (state == ARM || cnt_clear) begin
                to_cnt <= '0;
            end else if (to_cnt != CNT_MAX) begin
                to_cnt <= to_cnt + 1'b1;
            end

            if (cnt_clear) begin
                hi_cnt <= '0;
            end else if (state == HIGH && hi_cnt != CNT_MAX) begin
                hi_cnt <= hi_cnt + 1'b1;
            end

            if (cnt_clear) begin
                per_cnt <= '0;
            end else if ((state == HIGH || state == LOW) && per_cnt != CNT_MAX) begin
                per_cnt <= per_cnt + 1'b1;
            end

            if (lost_set) begin
                signal_lost <= 1'b1;
            end else if (lost_clr) begin
                signal_lost <= 1'b0;
            end

            if (fall_eval) begin
                if (width_ok) begin
                    width <= hi_len[CW-1:0];
                end else begin
                    width_err <= 1'b1;
                end
            end

            if (rise_eval) begin
                period <= per_len[CW] ? CNT_MAX : per_len[CW-1:0];
                if (period_ok) begin
                    period_valid <= 1'b1;
                end else begin
                    period_err <= 1'b1;
                end
            end

            // Division by repeated subtraction; the STEP/2 bias rounds to
            // nearest with ties going up. A new accepted width restarts it.
            if (conv_load) begin
                rem  <= (hi_len < PM_W) ? '0 : (hi_len - PM_W + HALF_W);
                q    <= '0;
                busy <= 1'b1;
            end else if (busy) begin
                if (rem >= ST_W && q < A_MAX) begin
                    rem <= rem - ST_W;
                    q   <= q + 1'b1;
                end else begin
                    angle       <= q;
                    angle_valid <= 1'b1;
                    busy        <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// tb/tb_servo_pwm_decoder.sv - scoreboard bench for servo_pwm_decoder with scaled timing

module tb_servo_pwm_decoder;

    localparam int PM   = 50;
    localparam int ST   = 5;
    localparam int AM   = 180;
    localparam int WMIN = 40;
    localparam int WMAX = 1000;
    localparam int PMIN = 1500;
    localparam int PMAX = 2500;
    localparam int TO   = 3000;
    localparam int CW   = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pwm_in;
    logic [7:0]    angle;
    logic [CW-1:0] width;
    logic [CW-1:0] period;
    logic          angle_valid, period_valid, width_err, period_err, signal_lost, busy;

    servo_pwm_decoder #(
        .PULSE_MIN(PM), .STEP(ST), .ANGLE_MAX(AM), .WIDTH_MIN(WMIN), .WIDTH_MAX(WMAX),
        .PERIOD_MIN(PMIN), .PERIOD_MAX(PMAX), .TIMEOUT(TO), .CW(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in),
        .angle(angle), .width(width), .period(period),
        .angle_valid(angle_valid), .period_valid(period_valid),
        .width_err(width_err), .period_err(period_err),
        .signal_lost(signal_lost), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int exp_angle_q[$];
    int exp_width_q[$];
    int exp_per_q[$];
    int exp_perr_q[$];
    int werr_pending = 0;
    bit have_rise = 1'b0;
    int prev_period = 0;
    int last_angle = 0;
    int last_width = 0;

    function automatic int ref_angle(input int h);
        int a;
        if (h < PM) return 0;
        a = (2 * (h - PM) + ST) / (2 * ST);
        if (a > AM) a = AM;
        return a;
    endfunction

    // Scoreboard: every strobe pops the expectation queued when stimulus was driven.
    task automatic sample_outputs();
        int a, w, p;
        if (angle_valid === 1'b1) begin
            checks++;
            if (exp_angle_q.size() == 0) begin
                errors++;
                $display("FAIL angle_valid_unexpected: got angle %0d width %0d, required no strobe", angle, width);
            end else begin
                a = exp_angle_q.pop_front();
                w = exp_width_q.pop_front();
                if (angle !== 8'(a) || width !== CW'(w)) begin
                    errors++;
                    $display("FAIL angle_decode: got angle %0d width %0d, required angle %0d width %0d", angle, width, a, w);
                end
            end
        end
        if (period_valid === 1'b1) begin
            checks++;
            if (exp_per_q.size() == 0) begin
                errors++;
                $display("FAIL period_valid_unexpected: got period %0d, required no strobe", period);
            end else begin
                p = exp_per_q.pop_front();
                if (period !== CW'(p)) begin
                    errors++;
                    $display("FAIL period_value: got %0d, required %0d", period, p);
                end
            end
        end
        if (period_err === 1'b1) begin
            checks++;
            if (exp_perr_q.size() == 0) begin
                errors++;
                $display("FAIL period_err_unexpected: got period %0d, required no strobe", period);
            end else begin
                p = exp_perr_q.pop_front();
                if (period !== CW'(p)) begin
                    errors++;
                    $display("FAIL period_err_value: got %0d, required %0d", period, p);
                end
            end
        end
        if (width_err === 1'b1) begin
            checks++;
            if (werr_pending == 0) begin
                errors++;
                $display("FAIL width_err_unexpected: got strobe, required none");
            end else begin
                werr_pending--;
            end
        end
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            sample_outputs();
        end
    endtask

    // exp_a < 0 means the angle comes from ref_angle().
    task automatic send_pulse(input int h, input int l, input bit chk_clear, input int exp_a);
        int a;
        if (have_rise) begin
            if (prev_period >= PMIN && prev_period <= PMAX) exp_per_q.push_back(prev_period);
            else exp_perr_q.push_back(prev_period);
        end
        if (h >= WMIN && h <= WMAX) begin
            a = (exp_a < 0) ? ref_angle(h) : exp_a;
            exp_angle_q.push_back(a);
            exp_width_q.push_back(h);
            last_angle = a;
            last_width = h;
        end else begin
            werr_pending++;
        end
        have_rise = 1'b1;
        prev_period = h + l;
        pwm_in = 1'b1;
        if (chk_clear) begin
            run_cycles(6);
            checks++;
            if (signal_lost !== 1'b0) begin
                errors++;
                $display("FAIL signal_lost_clear: got %0b, required 0", signal_lost);
            end
            run_cycles(h - 6);
        end else begin
            run_cycles(h);
        end
        pwm_in = 1'b0;
        run_cycles(l);
    endtask

    task automatic check_pending(input string name);
        checks++;
        if (exp_angle_q.size() != 0 || exp_per_q.size() != 0 || exp_perr_q.size() != 0 || werr_pending != 0) begin
            errors++;
            $display("FAIL %s_pending: got %0d angle %0d period %0d period_err %0d width_err outstanding, required 0",
                     name, exp_angle_q.size(), exp_per_q.size(), exp_perr_q.size(), werr_pending);
            exp_angle_q.delete();
            exp_width_q.delete();
            exp_per_q.delete();
            exp_perr_q.delete();
            werr_pending = 0;
        end
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if (angle !== 8'd0 || width !== '0 || period !== '0) begin
            errors++;
            $display("FAIL %s_data: got angle %0d width %0d period %0d, required 0 0 0", name, angle, width, period);
        end
        checks++;
        if ({angle_valid, period_valid, width_err, period_err, busy} !== 5'b0) begin
            errors++;
            $display("FAIL %s_strobes: got %05b, required 00000", name,
                     {angle_valid, period_valid, width_err, period_err, busy});
        end
        checks++;
        if (signal_lost !== 1'b1) begin
            errors++;
            $display("FAIL %s_signal_lost: got %0b, required 1", name, signal_lost);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pwm_in = 1'b0;
        run_cycles(5);
        check_reset_values("reset");
        rst_n = 1'b1;
        have_rise = 1'b0;
        run_cycles(5);
    endtask

    task automatic test_nominal();
        for (int i = 0; i < 10; i++) send_pulse(500, 1501, (i == 0), 90);
        check_pending("nominal");
    endtask

    task automatic test_rounding();
        send_pulse(202, 2001 - 202, 1'b0, 30);
        send_pulse(203, 2001 - 203, 1'b0, 31);
        send_pulse(50, 2001 - 50, 1'b0, 0);
        send_pulse(950, 2001 - 950, 1'b0, 180);
        send_pulse(1000, 2001 - 1000, 1'b0, 180);
        check_pending("rounding");
    endtask

    task automatic test_range_faults();
        send_pulse(39, 1961, 1'b0, -1);
        send_pulse(1001, 999, 1'b0, -1);
        checks++;
        if (angle !== 8'(last_angle) || width !== CW'(last_width)) begin
            errors++;
            $display("FAIL width_err_hold: got angle %0d width %0d, required angle %0d width %0d",
                     angle, width, last_angle, last_width);
        end
        send_pulse(500, 700, 1'b0, -1);
        send_pulse(500, 1501, 1'b0, -1);
        send_pulse(500, 1501, 1'b0, -1);
        check_pending("range_faults");
    endtask

    task automatic test_signal_loss();
        send_pulse(500, 1501, 1'b0, -1);
        run_cycles(TO + 100);
        checks++;
        if (signal_lost !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL signal_lost_set: got lost %0b busy %0b, required 1 0", signal_lost, busy);
        end
        have_rise = 1'b0;
        check_pending("signal_loss_hold");
        send_pulse(500, 1501, 1'b1, -1);
        send_pulse(300, 1701, 1'b0, -1);
        send_pulse(700, 1301, 1'b0, -1);
        check_pending("signal_loss_resume");
    endtask

    task automatic test_high_at_reset();
        rst_n = 1'b0;
        pwm_in = 1'b1;
        run_cycles(5);
        rst_n = 1'b1;
        run_cycles(300);
        checks++;
        if (signal_lost !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL partial_pulse: got lost %0b busy %0b, required 1 0", signal_lost, busy);
        end
        pwm_in = 1'b0;
        run_cycles(1500);
        have_rise = 1'b0;
        send_pulse(620, 1381, 1'b1, -1);
        send_pulse(620, 1381, 1'b0, -1);
        check_pending("high_at_reset");
    endtask

    task automatic test_reset_mid_conversion();
        rst_n = 1'b0;
        pwm_in = 1'b0;
        run_cycles(3);
        rst_n = 1'b1;
        have_rise = 1'b0;
        run_cycles(20);
        pwm_in = 1'b1;
        run_cycles(950);
        pwm_in = 1'b0;
        run_cycles(23);
        checks++;
        if (busy !== 1'b1 || width !== CW'(950)) begin
            errors++;
            $display("FAIL mid_conv_busy: got busy %0b width %0d, required 1 950", busy, width);
        end
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_conv_reset");
        run_cycles(3);
        rst_n = 1'b1;
        run_cycles(500);
        send_pulse(400, 1601, 1'b1, -1);
        send_pulse(400, 1601, 1'b0, -1);
        check_pending("mid_conv");
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_rounding();
        test_range_faults();
        test_signal_loss();
        test_high_at_reset();
        test_reset_mid_conversion();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
